riscv_mul: RTL and testbench

Iterative radix-2 shift-add multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU), sitting beside the divider in the execute stage. It captures operands on a start request and produces one 32-bit result after a fixed 35-cycle latency. While it works, it holds the pipeline frozen through `freeze_pipe`.

---
 rtl/riscv_mul.sv | 108 ++++++++++
 tb/tb_riscv_mul.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/riscv_mul.sv
// Iterative radix-2 shift-add multiplier for the RV32M multiply group.
// One result every 35 cycles; the pipeline is held frozen while it works.
module riscv_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_en,
  input  logic [1:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        freeze_pipe
);

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StPrep = 5'b00010,
    StMul  = 5'b00100,
    StSign = 5'b01000,
    StDone = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  funct_q;
  logic [63:0] acc_q;
  logic [5:0]  cnt_q;
  logic        neg_q;
  logic [31:0] result_q;

  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] sum33;
  logic [63:0] prod_fin;

  // a is signed for every op except MULHU; b only for MUL and MULH.
  assign sign_a   = a_q[31] & (funct_q != 2'b11);
  assign sign_b   = b_q[31] & ~funct_q[1];
  assign mag_a    = sign_a ? (~a_q + 32'd1) : a_q;
  assign mag_b    = sign_b ? (~b_q + 32'd1) : b_q;
  assign sum33    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  assign prod_fin = neg_q ? (~acc_q + 64'd1) : acc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (mul_en) state_d = StPrep;
      StPrep: state_d = StMul;
      StMul:  if (cnt_q == 6'd1) state_d = StSign;
      StSign: state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      funct_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mul_en) begin
            a_q     <= a;
            b_q     <= b;
            funct_q <= funct;
            acc_q   <= '0;
          end
        end
        StPrep: begin
          a_q   <= mag_a;
          acc_q <= {32'd0, mag_b};
          cnt_q <= 6'd32;
          neg_q <= sign_a ^ sign_b;
        end
        StMul: begin
          acc_q <= {sum33, acc_q[31:1]};
          cnt_q <= cnt_q - 6'd1;
        end
        StSign: begin
          // Result is latched here so it is already valid during DONE.
          acc_q    <= prod_fin;
          result_q <= (funct_q == 2'b00) ? prod_fin[31:0] : prod_fin[63:32];
        end
        default: ;
      endcase
    end
  end

  assign result      = result_q;
  assign done        = (state_q == StDone);
  assign freeze_pipe = ~rst & (((state_q == StIdle) & mul_en) | (state_q == StPrep) |
                               (state_q == StMul) | (state_q == StSign));

endmodule

// File: tb/tb_riscv_mul.sv
// Self-checking bench for riscv_mul: directed RV32M corner cases plus
// randomized operations checked against a plain 64-bit arithmetic model.
module tb_riscv_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_en;
  logic [1:0]  funct;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        done;
  logic        freeze_pipe;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res = 32'd0;

  riscv_mul dut (
    .clk         (clk),
    .rst         (rst),
    .mul_en      (mul_en),
    .funct       (funct),
    .a           (a),
    .b           (b),
    .result      (result),
    .done        (done),
    .freeze_pipe (freeze_pipe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: extend each operand to 64 bits by its signedness and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] sx, sy, p;
    logic        sa, sb;
    sa = (f != 2'b11) & x[31];
    sb = (f[1] == 1'b0) & y[31];
    sx = {{32{sa}}, x};
    sy = {{32{sb}}, y};
    p  = sx * sy;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Start an op in cycle T, then check every cycle through T+35.
  // With hold set, mul_en stays high and operands keep changing.
  task automatic run_op(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y,
                        input bit hold);
    logic [31:0] exp;
    exp = ref_mul(f, x, y);
    @(negedge clk);
    mul_en = 1'b1;
    funct  = f;
    a      = x;
    b      = y;
    #1;
    check("idle_done", {31'd0, done}, 32'd0);
    check("held_result", result, last_res);
    check("accept_freeze", {31'd0, freeze_pipe}, 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (!hold) mul_en = 1'b0;
      a     = $urandom;
      b     = $urandom;
      funct = 2'($urandom);
      #1;
      check("freeze", {31'd0, freeze_pipe}, {31'd0, (k <= 34)});
      check("done", {31'd0, done}, {31'd0, (k == 35)});
      if (k == 35) check("result", result, exp);
    end
    last_res = exp;
  endtask

  initial begin
    logic [31:0] x, y;
    logic [1:0]  f;
    bit          seen;

    // Reset together with mul_en: reset wins.
    rst    = 1'b1;
    mul_en = 1'b1;
    funct  = 2'b01;
    a      = 32'h1234_5678;
    b      = 32'h9abc_def0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_freeze", {31'd0, freeze_pipe}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst    = 1'b0;
    mul_en = 1'b0;
    @(negedge clk);
    #1;
    check("rst_state", {27'd0, dut.state_q}, 32'd1);
    check("rst_no_start", {31'd0, freeze_pipe}, 32'd0);

    // Directed corner cases
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'd0, 32'hFFFF_FFFB, 1'b0);

    // Reset in cycle T+10 aborts the op without a done pulse.
    @(negedge clk);
    mul_en = 1'b1;
    funct  = 2'b01;
    a      = 32'hDEAD_BEEF;
    b      = 32'h0BAD_F00D;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      mul_en = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_freeze", {31'd0, freeze_pipe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_state", {27'd0, dut.state_q}, 32'd1);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_freeze2", {31'd0, freeze_pipe}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("mid_rst_no_done", {31'd0, seen}, 32'd0);
    last_res = 32'd0;
    run_op(2'b11, 32'd3, 32'd5, 1'b0);

    // Back-to-back with mul_en held high and operands changing.
    run_op(2'b00, 32'h0001_0003, 32'h0000_0101, 1'b1);
    run_op(2'b01, 32'hFFFF_FF00, 32'h7FFF_FFFF, 1'b0);

    // Randomized ops, biased toward sign-boundary operands.
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'h8000_0000;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'd0;
        default: ;
      endcase
      run_op(f, x, y, bit'($urandom_range(0, 1)));
    end

    @(negedge clk);
    mul_en = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
